// File: rtl/wb_ram_xilinx_ctrl_pkg.sv
// Shared constants and types for the Wishbone RAM controller and its address decoder.
package wb_ram_pkg;

    localparam int unsigned BANK_WORDS = 2048;
    localparam int unsigned BANK_BYTES = 8192;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WACK,
        ST_RDATA,
        ST_ERR
    } state_t;

    // A single bank still needs a 1-bit index so port widths never collapse to zero.
    function automatic int unsigned bank_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_ram_xilinx_ctrl_if.sv
// Wishbone B3 bus bundle between the interconnect (master) and the RAM controller (slave).
interface wb_ram_xilinx_ctrl_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_ram_xilinx_ctrl_addr_decode.sv
// Combinational byte-address decode into range flag, bank index and word-within-bank.
module wb_ram_addr_decode
    import wb_ram_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned BANK_W   = bank_bits(NUM_BANKS)
) (
    input  logic [31:0]       i_adr,
    output logic              o_in_range,
    output logic [BANK_W-1:0] o_bank,
    output logic [10:0]       o_word
);

    logic [31:0] w_offset;

    // Addresses below the base wrap to a huge offset and fall out of range naturally.
    assign w_offset   = i_adr - BASE_ADDR;
    assign o_in_range = (w_offset < 32'(NUM_BANKS * BANK_BYTES));
    assign o_word     = w_offset[12:2];

    generate
        if (NUM_BANKS > 1) begin : g_multi
            assign o_bank = w_offset[13 +: BANK_W];
        end else begin : g_single
            assign o_bank = '0;
        end
    endgenerate

endmodule

// File: rtl/wb_ram_xilinx_ctrl.sv
// Wishbone B3 slave front end for banked on-chip RAM: decode, byte writes,
// read-data mux and ack/err generation with zero-wait-state linear burst reads.
module wb_ram_xilinx_ctrl
    import wb_ram_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wb_ram_xilinx_ctrl_if.slave     wb,
    output logic [3:0]              ram_we,
    output logic [31:0]             ram_din,
    output logic [15:0]             ram_waddr,
    output logic [15:0]             ram_raddr,
    output logic [NUM_BANKS-1:0]    ram_bank_select,
    input  logic [32*NUM_BANKS-1:0] ram_dout
);

    localparam int unsigned BANK_W = bank_bits(NUM_BANKS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BANK_W-1:0] r_bank;
    logic [BANK_W-1:0] w_bank_nxt;

    logic              w_cur_in_range;
    logic [BANK_W-1:0] w_cur_bank;
    logic [10:0]       w_cur_word;
    logic              w_nxt_in_range;
    logic [BANK_W-1:0] w_nxt_bank;
    logic [10:0]       w_nxt_word;
    logic [31:0]       w_adr_nxt;

    logic              w_req;
    logic              w_burst;
    logic              w_ack;
    logic              w_err;
    logic [31:0]       w_dat;
    logic [31:0]       w_bank_dout [NUM_BANKS];

    assign w_adr_nxt = wb.wb_adr_i + 32'd4;

    wb_ram_addr_decode #(.NUM_BANKS(NUM_BANKS), .BASE_ADDR(BASE_ADDR)) u_dec_cur (
        .i_adr      (wb.wb_adr_i),
        .o_in_range (w_cur_in_range),
        .o_bank     (w_cur_bank),
        .o_word     (w_cur_word)
    );

    wb_ram_addr_decode #(.NUM_BANKS(NUM_BANKS), .BASE_ADDR(BASE_ADDR)) u_dec_nxt (
        .i_adr      (w_adr_nxt),
        .o_in_range (w_nxt_in_range),
        .o_bank     (w_nxt_bank),
        .o_word     (w_nxt_word)
    );

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_dout
            assign w_bank_dout[g] = ram_dout[32*g +: 32];
        end
    endgenerate

    assign w_req   = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_burst = w_req & (wb.wb_cti_i == CTI_INCR) & (wb.wb_bte_i == BTE_LINEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bank  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bank  <= w_bank_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bank_nxt      = r_bank;
        w_ack           = 1'b0;
        w_err           = 1'b0;
        w_dat           = '0;
        ram_we          = '0;
        ram_din         = '0;
        ram_waddr       = '0;
        ram_raddr       = '0;
        ram_bank_select = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (!w_cur_in_range) begin
                        w_state_nxt = ST_ERR;
                    end else if (wb.wb_we_i) begin
                        ram_we          = wb.wb_sel_i;
                        ram_din         = wb.wb_dat_i;
                        ram_waddr       = 16'(w_cur_word);
                        ram_bank_select = NUM_BANKS'(1) << w_cur_bank;
                        w_state_nxt     = ST_WACK;
                    end else begin
                        ram_raddr       = 16'(w_cur_word);
                        ram_bank_select = NUM_BANKS'(1) << w_cur_bank;
                        w_bank_nxt      = w_cur_bank;
                        w_state_nxt     = ST_RDATA;
                    end
                end
            end
            ST_WACK: begin
                w_ack       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_RDATA: begin
                w_ack = 1'b1;
                w_dat = w_bank_dout[r_bank];
                // Prefetch the following word while acking this one to keep one beat per cycle.
                if (w_burst && w_nxt_in_range) begin
                    ram_raddr       = 16'(w_nxt_word);
                    ram_bank_select = NUM_BANKS'(1) << w_nxt_bank;
                    w_bank_nxt      = w_nxt_bank;
                    w_state_nxt     = ST_RDATA;
                end else if (w_burst) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (!wb.wb_cyc_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign wb.wb_ack_o = w_ack;
    assign wb.wb_err_o = w_err;
    assign wb.wb_dat_o = w_dat;

endmodule
